// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - RV32I load/store funct3 constants
//   - access size encoding (size_e) and FSM state encoding (state_e)
//   - size_of(): funct3 -> access size
// Optional feature macro: LSU_MISALIGN_TRAP_EN (used in lsu_align).
package lsu_pkg;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;
    localparam logic [2:0] FUNCT3_SB  = 3'b000;
    localparam logic [2:0] FUNCT3_SH  = 3'b001;
    localparam logic [2:0] FUNCT3_SW  = 3'b010;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } size_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } state_e;

    // funct3[1:0] = 11 has no RV32I meaning; it is treated as a word access.
    function automatic size_e size_of(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   size_of = BYTE;
            2'b01:   size_of = HALF;
            default: size_of = WORD;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: purely combinational lane logic for the LSU.
//   funct3_i   : RV32I funct3 (size in [1:0], unsigned-load flag in [2])
//   addr_lo_i  : byte offset within the word
//   wdata_i    : right-justified store data
//   rdata_i    : raw word from dmem
//   mask_o     : dmem byte enables
//   wdata_o    : store data replicated across lanes
//   misaligned_o : misaligned flag (only with LSU_MISALIGN_TRAP_EN, else 0)
//   rdata_o    : extracted and sign/zero-extended load data
// Optional feature macro: LSU_MISALIGN_TRAP_EN.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  mask_o,
    output logic [31:0] wdata_o,
    output logic        misaligned_o,
    output logic [31:0] rdata_o
);

    size_e       size;
    logic [1:0]  off;
    logic [31:0] shifted;
    logic        sext;

    // The effective offset drops the low address bits a half/word cannot use,
    // so an undetected misaligned access behaves as the aligned one below it.
    always_comb begin
        size    = size_of(funct3_i);
        off     = 2'b00;
        mask_o  = 4'b1111;
        wdata_o = wdata_i;
        case (size)
            BYTE: begin
                off     = addr_lo_i;
                mask_o  = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            HALF: begin
                off     = {addr_lo_i[1], 1'b0};
                mask_o  = 4'b0011 << {addr_lo_i[1], 1'b0};
                wdata_o = {2{wdata_i[15:0]}};
            end
            default: begin
                off     = 2'b00;
                mask_o  = 4'b1111;
                wdata_o = wdata_i;
            end
        endcase
    end

    always_comb begin
        shifted = rdata_i >> {off, 3'b000};
        sext    = ~funct3_i[2];
        case (size)
            BYTE:    rdata_o = {{24{sext & shifted[7]}}, shifted[7:0]};
            HALF:    rdata_o = {{16{sext & shifted[15]}}, shifted[15:0]};
            default: rdata_o = shifted;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    always_comb begin
        case (size)
            HALF:    misaligned_o = addr_lo_i[0];
            WORD:    misaligned_o = |addr_lo_i;
            default: misaligned_o = 1'b0;
        endcase
    end
`else
    assign misaligned_o = 1'b0;
`endif

endmodule

// File: rtl/lsu.sv
// lsu: load/store unit between the MEM stage and dmem. One access in flight.
//   clk, rst_n (async, active low)
//   ip_req_valid/op_req_ready, ip_req_is_store, ip_req_funct3, ip_req_addr,
//   ip_req_wdata : request from the pipeline
//   op_resp_valid/ip_resp_ready, op_resp_rdata, op_resp_misaligned : response
//   op_data_addr, op_data_wr, op_data_rd, op_data_mask, op_data_from_proc :
//   dmem request; ip_data_valid, ip_data_from_dmem : dmem read return
// Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned requests skip
// dmem and respond with op_resp_misaligned=1).
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ip_req_valid,
    output logic              op_req_ready,
    input  logic              ip_req_is_store,
    input  logic [2:0]        ip_req_funct3,
    input  logic [ADDR_W-1:0] ip_req_addr,
    input  logic [31:0]       ip_req_wdata,
    output logic              op_resp_valid,
    input  logic              ip_resp_ready,
    output logic [31:0]       op_resp_rdata,
    output logic              op_resp_misaligned,
    output logic [ADDR_W-1:0] op_data_addr,
    output logic              op_data_wr,
    output logic [3:0]        op_data_mask,
    output logic [31:0]       op_data_from_proc,
    output logic              op_data_rd,
    input  logic              ip_data_valid,
    input  logic [31:0]       ip_data_from_dmem
);

    state_e            state_q, state_d;
    logic              is_store_q;
    logic [2:0]        funct3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       resp_rdata_q, resp_rdata_d;
    logic              resp_mis_q, resp_mis_d;
    logic              accept;

    logic [2:0]        al_funct3;
    logic [1:0]        al_addr_lo;
    logic [31:0]       al_wdata;
    logic [3:0]        al_mask;
    logic [31:0]       al_store_data;
    logic              al_mis;
    logic [31:0]       al_load_data;

    assign accept = ip_req_valid && (state_q == IDLE);

    // One aligner serves both phases: in IDLE it looks at the incoming
    // request (for the accept-time misalignment decision), afterwards at the
    // registered request that drives dmem.
    assign al_funct3  = (state_q == IDLE) ? ip_req_funct3    : funct3_q;
    assign al_addr_lo = (state_q == IDLE) ? ip_req_addr[1:0] : addr_q[1:0];
    assign al_wdata   = (state_q == IDLE) ? ip_req_wdata     : wdata_q;

    lsu_align u_align (
        .funct3_i     (al_funct3),
        .addr_lo_i    (al_addr_lo),
        .wdata_i      (al_wdata),
        .rdata_i      (ip_data_from_dmem),
        .mask_o       (al_mask),
        .wdata_o      (al_store_data),
        .misaligned_o (al_mis),
        .rdata_o      (al_load_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            is_store_q   <= 1'b0;
            funct3_q     <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            resp_rdata_q <= '0;
            resp_mis_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            resp_rdata_q <= resp_rdata_d;
            resp_mis_q   <= resp_mis_d;
            if (accept) begin
                is_store_q <= ip_req_is_store;
                funct3_q   <= ip_req_funct3;
                addr_q     <= ip_req_addr;
                wdata_q    <= ip_req_wdata;
            end
        end
    end

    always_comb begin
        state_d           = state_q;
        resp_rdata_d      = resp_rdata_q;
        resp_mis_d        = resp_mis_q;
        op_req_ready      = 1'b0;
        op_resp_valid     = 1'b0;
        op_data_wr        = 1'b0;
        op_data_rd        = 1'b0;
        op_data_mask      = '0;
        op_data_from_proc = '0;
        case (state_q)
            IDLE: begin
                op_req_ready = 1'b1;
                if (ip_req_valid) begin
                    // al_mis is constant 0 unless the trap feature is built in.
                    if (al_mis) begin
                        state_d      = RESP;
                        resp_rdata_d = '0;
                        resp_mis_d   = 1'b1;
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                op_data_mask = al_mask;
                if (is_store_q) begin
                    op_data_wr        = 1'b1;
                    op_data_from_proc = al_store_data;
                    state_d           = RESP;
                    resp_rdata_d      = '0;
                    resp_mis_d        = 1'b0;
                end else begin
                    op_data_rd = 1'b1;
                    if (ip_data_valid) begin
                        state_d      = RESP;
                        resp_rdata_d = al_load_data;
                        resp_mis_d   = 1'b0;
                    end
                end
            end
            RESP: begin
                op_resp_valid = 1'b1;
                if (ip_resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign op_data_addr       = {addr_q[ADDR_W-1:2], 2'b00};
    assign op_resp_rdata      = resp_rdata_q;
    assign op_resp_misaligned = resp_mis_q;

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ip_req_valid;
    logic        op_req_ready;
    logic        ip_req_is_store;
    logic [2:0]  ip_req_funct3;
    logic [31:0] ip_req_addr;
    logic [31:0] ip_req_wdata;
    logic        op_resp_valid;
    logic        ip_resp_ready;
    logic [31:0] op_resp_rdata;
    logic        op_resp_misaligned;
    logic [31:0] op_data_addr;
    logic        op_data_wr;
    logic [3:0]  op_data_mask;
    logic [31:0] op_data_from_proc;
    logic        op_data_rd;
    logic        ip_data_valid;
    logic [31:0] ip_data_from_dmem;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lsu #(.ADDR_W(32)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .ip_req_valid       (ip_req_valid),
        .op_req_ready       (op_req_ready),
        .ip_req_is_store    (ip_req_is_store),
        .ip_req_funct3      (ip_req_funct3),
        .ip_req_addr        (ip_req_addr),
        .ip_req_wdata       (ip_req_wdata),
        .op_resp_valid      (op_resp_valid),
        .ip_resp_ready      (ip_resp_ready),
        .op_resp_rdata      (op_resp_rdata),
        .op_resp_misaligned (op_resp_misaligned),
        .op_data_addr       (op_data_addr),
        .op_data_wr         (op_data_wr),
        .op_data_mask       (op_data_mask),
        .op_data_from_proc  (op_data_from_proc),
        .op_data_rd         (op_data_rd),
        .ip_data_valid      (ip_data_valid),
        .ip_data_from_dmem  (ip_data_from_dmem)
    );

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct {
        int          wr_cnt;
        int          rd_cnt;
        logic [31:0] daddr;
        logic [3:0]  mask;
        logic [31:0] dwdata;
        int          lat;
        logic [31:0] rdata;
        logic        mis;
        bit          stable;
        bit          idle_after;
        bit          timeout;
        time         t_acc;
    } obs_t;

    typedef struct {
        bit          acc;
        logic [31:0] daddr;
        logic [3:0]  mask;
        logic [31:0] dwdata;
        logic [31:0] rdata;
        logic        mis;
    } exp_t;

    // Reference: access size in bytes, offset rounded down to the size,
    // lanes and extension computed arithmetically.
    function automatic exp_t model(input bit st, input logic [2:0] f3,
                                   input logic [31:0] addr, input logic [31:0] wdata,
                                   input logic [31:0] dword);
        exp_t        e;
        int unsigned sz, a4, off;
        logic [63:0] v;
        sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        a4 = addr % 4;
        e.daddr  = addr - a4;
        e.mask   = '0;
        e.dwdata = '0;
        e.rdata  = '0;
        e.mis    = 1'b0;
        e.acc    = 1'b1;
        if (TRAP && ((a4 % sz) != 0)) begin
            e.acc = 1'b0;
            e.mis = 1'b1;
        end else begin
            off    = (a4 / sz) * sz;
            e.mask = 4'(((1 << sz) - 1) << off);
            for (int k = 0; k < 4; k++)
                e.dwdata[8*k +: 8] = wdata[8*(k % sz) +: 8];
            if (!st) begin
                v = ({32'd0, dword} >> (8 * off)) & ((64'd1 << (8 * sz)) - 64'd1);
                if (!f3[2] && sz < 4 && v[8*sz-1])
                    v = v | (~64'd0 << (8 * sz));
                e.rdata = v[31:0];
            end
        end
        return e;
    endfunction

    // Drives one request from IDLE through to the response handshake and
    // records what the DUT did. Must be entered 1 time unit after a posedge.
    task automatic run_req(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] dword,
                           input int data_lat, input int ready_lat, output obs_t o);
        int cycles;
        o = '{default: 0};
        o.stable = 1'b1;
        ip_req_valid    = 1'b1;
        ip_req_is_store = st;
        ip_req_funct3   = f3;
        ip_req_addr     = addr;
        ip_req_wdata    = wdata;
        @(posedge clk);
        o.t_acc = $time;
        #1;
        ip_req_valid = 1'b0;
        ip_req_wdata = $urandom;
        cycles = 1;
        while (!op_resp_valid && cycles < 40) begin
            if (op_data_wr) begin
                o.wr_cnt++;
                o.daddr  = op_data_addr;
                o.mask   = op_data_mask;
                o.dwdata = op_data_from_proc;
            end
            if (op_data_rd) begin
                o.rd_cnt++;
                o.daddr = op_data_addr;
                o.mask  = op_data_mask;
                ip_data_valid     = (o.rd_cnt > data_lat);
                ip_data_from_dmem = ip_data_valid ? dword : $urandom;
            end
            @(posedge clk);
            #1;
            ip_data_valid     = 1'b0;
            ip_data_from_dmem = $urandom;
            cycles++;
        end
        if (!op_resp_valid) begin
            o.timeout = 1'b1;
            return;
        end
        o.lat   = cycles;
        o.rdata = op_resp_rdata;
        o.mis   = op_resp_misaligned;
        for (int i = 0; i < ready_lat; i++) begin
            ip_req_valid    = 1'b1;
            ip_req_is_store = $urandom_range(0, 1);
            ip_req_funct3   = 3'($urandom_range(0, 2));
            ip_req_addr     = $urandom;
            @(posedge clk);
            #1;
            if (op_resp_valid !== 1'b1 || op_resp_rdata !== o.rdata ||
                op_resp_misaligned !== o.mis || op_req_ready !== 1'b0 || op_data_wr || op_data_rd)
                o.stable = 1'b0;
        end
        ip_req_valid  = 1'b0;
        ip_resp_ready = 1'b1;
        @(posedge clk);
        #1;
        ip_resp_ready = 1'b0;
        o.idle_after = (op_req_ready === 1'b1) && (op_resp_valid === 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ip_req_valid = 1'b0; ip_req_is_store = 1'b0; ip_req_funct3 = '0;
        ip_req_addr = '0; ip_req_wdata = '0; ip_resp_ready = 1'b0;
        ip_data_valid = 1'b0; ip_data_from_dmem = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({op_resp_valid, op_resp_misaligned, op_data_wr, op_data_rd} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_strobes: got %b expected 0000",
                     {op_resp_valid, op_resp_misaligned, op_data_wr, op_data_rd});
        end
        checks++;
        if (op_resp_rdata !== 32'd0 || op_data_addr !== 32'd0 || op_data_from_proc !== 32'd0 ||
            op_data_mask !== 4'd0) begin
            errors++;
            $display("FAIL reset_data: rdata=%h addr=%h wdata=%h mask=%b expected all 0",
                     op_resp_rdata, op_data_addr, op_data_from_proc, op_data_mask);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (op_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b expected 1", op_req_ready);
        end
    endtask

    task automatic test_directed();
        obs_t o;
        exp_t e;
        // SB to the top byte lane
        e = model(1'b1, 3'b000, 32'h103, 32'hA5, 32'h0);
        run_req(1'b1, 3'b000, 32'h103, 32'hA5, 32'h0, 0, 0, o);
        checks++;
        if (o.wr_cnt !== 1 || o.daddr !== 32'h100 || o.mask !== 4'b1000 || o.dwdata !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL sb_dmem: wr=%0d addr=%h mask=%b data=%h expected 1 00000100 1000 a5a5a5a5",
                     o.wr_cnt, o.daddr, o.mask, o.dwdata);
        end
        checks++;
        if (o.rdata !== e.rdata || o.mis !== 1'b0 || o.lat !== 2) begin
            errors++;
            $display("FAIL sb_resp: rdata=%h mis=%b lat=%0d expected %h 0 2", o.rdata, o.mis, o.lat, e.rdata);
        end
        // LH / LHU / LB from the same word
        run_req(1'b0, 3'b001, 32'h202, 32'h0, 32'h80017FFF, 0, 0, o);
        checks++;
        if (o.rdata !== 32'hFFFF8001 || o.lat !== 2 || o.mask !== 4'b1100) begin
            errors++;
            $display("FAIL lh: rdata=%h lat=%0d mask=%b expected ffff8001 2 1100", o.rdata, o.lat, o.mask);
        end
        run_req(1'b0, 3'b101, 32'h202, 32'h0, 32'h80017FFF, 0, 0, o);
        checks++;
        if (o.rdata !== 32'h00008001) begin
            errors++;
            $display("FAIL lhu: rdata=%h expected 00008001", o.rdata);
        end
        run_req(1'b0, 3'b000, 32'h201, 32'h0, 32'h80017FFF, 0, 0, o);
        checks++;
        if (o.rdata !== 32'h0000007F || o.mask !== 4'b0010 || o.daddr !== 32'h200) begin
            errors++;
            $display("FAIL lb: rdata=%h mask=%b addr=%h expected 0000007f 0010 00000200",
                     o.rdata, o.mask, o.daddr);
        end
        // LW with dmem stalling 3 cycles
        run_req(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 3, 0, o);
        checks++;
        if (o.timeout || o.rdata !== 32'hDEADBEEF || o.lat !== 5 || o.rd_cnt !== 4) begin
            errors++;
            $display("FAIL lw_wait: timeout=%0d rdata=%h lat=%0d rd=%0d expected 0 deadbeef 5 4",
                     o.timeout, o.rdata, o.lat, o.rd_cnt);
        end
        // SW to a misaligned address
        e = model(1'b1, 3'b010, 32'h106, 32'h12345678, 32'h0);
        run_req(1'b1, 3'b010, 32'h106, 32'h12345678, 32'h0, 0, 0, o);
        checks++;
        if (o.wr_cnt !== (e.acc ? 1 : 0) || o.mis !== e.mis || o.rdata !== 32'd0 ||
            (e.acc && (o.mask !== 4'b1111 || o.daddr !== 32'h104 || o.dwdata !== 32'h12345678))) begin
            errors++;
            $display("FAIL sw_misaligned: wr=%0d mis=%b rdata=%h mask=%b addr=%h expected wr=%0d mis=%b",
                     o.wr_cnt, o.mis, o.rdata, o.mask, o.daddr, e.acc ? 1 : 0, e.mis);
        end
    endtask

    task automatic test_backpressure();
        obs_t o;
        run_req(1'b0, 3'b000, 32'h43, 32'h0, 32'h9A000000, 0, 4, o);
        checks++;
        if (o.rdata !== 32'hFFFFFF9A) begin
            errors++;
            $display("FAIL bp_rdata: got %h expected ffffff9a", o.rdata);
        end
        checks++;
        if (!o.stable) begin
            errors++;
            $display("FAIL bp_stable: got unstable/accepting response expected stable with ready=0");
        end
        checks++;
        if (!o.idle_after) begin
            errors++;
            $display("FAIL bp_idle: req_ready=%b resp_valid=%b expected 1 0", op_req_ready, op_resp_valid);
        end
        run_req(1'b1, 3'b001, 32'h82, 32'h0000BEEF, 32'h0, 0, 0, o);
        checks++;
        if (o.wr_cnt !== 1 || o.mask !== 4'b1100 || o.dwdata !== 32'hBEEFBEEF || o.lat !== 2) begin
            errors++;
            $display("FAIL bp_next: wr=%0d mask=%b data=%h lat=%0d expected 1 1100 beefbeef 2",
                     o.wr_cnt, o.mask, o.dwdata, o.lat);
        end
    endtask

    task automatic test_back_to_back();
        obs_t o;
        time  t0, t1;
        run_req(1'b0, 3'b010, 32'h0, 32'h0, 32'h1, 0, 0, o);
        t0 = o.t_acc;
        run_req(1'b1, 3'b010, 32'h4, 32'h2, 32'h0, 0, 0, o);
        t1 = o.t_acc;
        checks++;
        if (t1 - t0 !== 30) begin
            errors++;
            $display("FAIL back_to_back: accept spacing %0t expected 30", t1 - t0);
        end
    endtask

    task automatic test_random();
        obs_t        o;
        exp_t        e;
        logic [2:0]  ld_f3 [6] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101};
        bit          st;
        logic [2:0]  f3;
        logic [31:0] addr, wdata, dword;
        int          dl, rl, exp_lat;
        for (int n = 0; n < 40; n++) begin
            st    = $urandom_range(0, 1);
            f3    = st ? 3'($urandom_range(0, 2)) : ld_f3[$urandom_range(0, 5)];
            addr  = $urandom;
            wdata = $urandom;
            dword = $urandom;
            dl    = $urandom_range(0, 2);
            rl    = $urandom_range(0, 2);
            e     = model(st, f3, addr, wdata, dword);
            exp_lat = !e.acc ? 1 : st ? 2 : 2 + dl;
            run_req(st, f3, addr, wdata, dword, dl, rl, o);
            checks++;
            if (o.timeout || o.rdata !== e.rdata || o.mis !== e.mis || o.lat !== exp_lat) begin
                errors++;
                $display("FAIL rand_resp[%0d]: rdata=%h mis=%b lat=%0d expected %h %b %0d (st=%0d f3=%b addr=%h)",
                         n, o.rdata, o.mis, o.lat, e.rdata, e.mis, exp_lat, st, f3, addr);
            end
            checks++;
            if (o.wr_cnt !== ((e.acc && st) ? 1 : 0) || o.rd_cnt !== ((e.acc && !st) ? dl + 1 : 0) ||
                (e.acc && (o.daddr !== e.daddr || o.mask !== e.mask)) ||
                (e.acc && st && o.dwdata !== e.dwdata)) begin
                errors++;
                $display("FAIL rand_dmem[%0d]: wr=%0d rd=%0d addr=%h mask=%b data=%h expected addr=%h mask=%b data=%h",
                         n, o.wr_cnt, o.rd_cnt, o.daddr, o.mask, o.dwdata, e.daddr, e.mask, e.dwdata);
            end
            checks++;
            if (!o.stable || !o.idle_after) begin
                errors++;
                $display("FAIL rand_hs[%0d]: stable=%0d idle_after=%0d expected 1 1", n, o.stable, o.idle_after);
            end
        end
    endtask

    task automatic test_reset_mid();
        ip_req_valid    = 1'b1;
        ip_req_is_store = 1'b1;
        ip_req_funct3   = 3'b010;
        ip_req_addr     = 32'h20;
        ip_req_wdata    = 32'h55AA55AA;
        @(posedge clk);
        #1;
        ip_req_valid = 1'b0;
        checks++;
        if (op_data_wr !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_pre: wr=%b expected 1", op_data_wr);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (op_data_wr !== 1'b0 || op_resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_drop: wr=%b resp_valid=%b expected 0 0", op_data_wr, op_resp_valid);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (op_resp_valid !== 1'b0 || op_req_ready !== 1'b1 || op_data_wr !== 1'b0) begin
                errors++;
                $display("FAIL rst_mid_after[%0d]: resp_valid=%b ready=%b wr=%b expected 0 1 0",
                         i, op_resp_valid, op_req_ready, op_data_wr);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
